// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// Each digit slot starts with an all-off blanking window, then drives one
// anode with its segment pattern. A frame is four slots; all display data is
// latched into shadow registers at every frame start so mid-frame input
// changes never tear the displayed value. Every output is a flop.
module seven_seg_scanner #(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_mask,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);

  localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 2;
  localparam logic [CW-1:0] CYC_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  // Idle (deasserted) level of each output for the chosen polarity.
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'b1111    : 4'b0000;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1       : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cyc_cnt_r, cyc_cnt_s;
  logic [1:0]    digit_idx_r, digit_idx_s;
  logic          frame_start_s;

  logic [6:0]    seg_sh_r [0:3];
  logic [6:0]    seg_sh_s [0:3];
  logic [3:0]    dp_sh_r, dp_sh_s;
  logic [3:0]    mask_sh_r, mask_sh_s;

  logic [3:0]    an_on_s;
  logic [6:0]    seg_on_s;
  logic          dp_on_s;

  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic          frame_tick_r;

  // Next-state logic: slot sequencing, digit advance and frame-start detect.
  always_comb begin
    state_s       = state_r;
    cyc_cnt_s     = cyc_cnt_r;
    digit_idx_s   = digit_idx_r;
    frame_start_s = 1'b0;
    if (!enable) begin
      state_s     = IDLE;
      cyc_cnt_s   = '0;
      digit_idx_s = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s       = BLANK;
          cyc_cnt_s     = '0;
          digit_idx_s   = 2'd0;
          frame_start_s = 1'b1;
        end
        BLANK: begin
          cyc_cnt_s = cyc_cnt_r + CW'(1);
          if (cyc_cnt_r == BLANK_LAST) begin
            state_s = DRIVE;
          end else begin
            state_s = BLANK;
          end
        end
        DRIVE: begin
          if (cyc_cnt_r == CYC_LAST) begin
            // Digit 3 -> 0 wraps naturally in two bits; that wrap opens a frame.
            state_s       = BLANK;
            cyc_cnt_s     = '0;
            digit_idx_s   = digit_idx_r + 2'd1;
            frame_start_s = (digit_idx_r == 2'd3);
          end else begin
            cyc_cnt_s = cyc_cnt_r + CW'(1);
          end
        end
        default: begin
          state_s     = IDLE;
          cyc_cnt_s   = '0;
          digit_idx_s = 2'd0;
        end
      endcase
    end
  end

  // Shadow capture: display data is only sampled at a frame start.
  always_comb begin
    seg_sh_s  = seg_sh_r;
    dp_sh_s   = dp_sh_r;
    mask_sh_s = mask_sh_r;
    if (frame_start_s) begin
      seg_sh_s[0] = seg0;
      seg_sh_s[1] = seg1;
      seg_sh_s[2] = seg2;
      seg_sh_s[3] = seg3;
      dp_sh_s     = dp_in;
      mask_sh_s   = digit_mask;
    end else begin
      mask_sh_s = mask_sh_r;
    end
  end

  // Active-high output image for the upcoming cycle, built from next state so
  // the registered outputs line up with the state they belong to.
  always_comb begin
    an_on_s  = 4'b0000;
    seg_on_s = 7'b0000000;
    dp_on_s  = 1'b0;
    if ((state_s == DRIVE) && !mask_sh_s[digit_idx_s]) begin
      an_on_s  = 4'b0001 << digit_idx_s;
      seg_on_s = seg_sh_s[digit_idx_s];
      dp_on_s  = dp_sh_s[digit_idx_s];
    end else begin
      an_on_s  = 4'b0000;
    end
  end

  // State, counters, shadows and polarity-adjusted output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cyc_cnt_r    <= '0;
      digit_idx_r  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        seg_sh_r[i] <= 7'd0;
      end
      dp_sh_r      <= 4'd0;
      mask_sh_r    <= 4'd0;
      an_r         <= AN_OFF;
      seg_r        <= SEG_OFF;
      dp_r         <= DP_OFF;
      frame_tick_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cyc_cnt_r    <= cyc_cnt_s;
      digit_idx_r  <= digit_idx_s;
      for (int i = 0; i < 4; i++) begin
        seg_sh_r[i] <= seg_sh_s[i];
      end
      dp_sh_r      <= dp_sh_s;
      mask_sh_r    <= mask_sh_s;
      an_r         <= AN_ACTIVE_LOW  ? ~an_on_s  : an_on_s;
      seg_r        <= SEG_ACTIVE_LOW ? ~seg_on_s : seg_on_s;
      dp_r         <= SEG_ACTIVE_LOW ? ~dp_on_s  : dp_on_s;
      frame_tick_r <= frame_start_s;
    end
  end

  assign an_out     = an_r;
  assign seg_out    = seg_r;
  assign dp_out     = dp_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Frame position k (0..31) counts cycles after a frame-start edge.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [3:0] dp_in;
  logic [3:0] digit_mask;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] an_out;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  // Bench copy of what the display should have latched at the last frame start.
  logic [6:0] sh_pat [4];
  logic [3:0] sh_mask;
  logic [3:0] sh_dp;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DIGIT_CYCLES  (8),
    .BLANK_CYCLES  (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .seg0      (seg0),
    .seg1      (seg1),
    .seg2      (seg2),
    .seg3      (seg3),
    .dp_in     (dp_in),
    .digit_mask(digit_mask),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    sh_pat[0] = seg0;
    sh_pat[1] = seg1;
    sh_pat[2] = seg2;
    sh_pat[3] = seg3;
    sh_mask   = digit_mask;
    sh_dp     = dp_in;
  endtask

  // Expected {an_out, seg_out, dp_out} at frame position k.
  function automatic logic [11:0] exp_out(input int k);
    int slot;
    int pos;
    logic [3:0] one;
    slot = k / 8;
    pos  = k % 8;
    if (pos < 2 || sh_mask[slot]) return {4'b1111, 7'b1111111, 1'b1};
    one = 4'b0001 << slot;
    return {~one, ~sh_pat[slot], ~sh_dp[slot]};
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    reset = 1'b1; enable = 1'b1;
    seg0 = 7'h06; seg1 = 7'h5B; seg2 = 7'h4F; seg3 = 7'h66;
    dp_in = 4'b0000; digit_mask = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== 12'hFFF) begin bad++; $display("FAIL reset_out got=%h want=fff", got); end
      total++;
      if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    end
    total++;
    if (dut.cyc_cnt_r !== 3'd0 || dut.digit_idx_r !== 2'd0 || 2'(dut.state_r) !== 2'd0) begin
      bad++; $display("FAIL reset_state cyc=%0d dig=%0d st=%0d want 0/0/0",
                      dut.cyc_cnt_r, dut.digit_idx_r, dut.state_r);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [11:0] got;
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    seg_tab[0] = 7'h79; seg_tab[1] = 7'h24; seg_tab[2] = 7'h30; seg_tab[3] = 7'h19;
    for (int f = 0; f < 2; f++) begin
      capture();
      for (int k = 0; k < 32; k++) begin
        step();
        got = {an_out, seg_out, dp_out};
        total++;
        if (got !== exp_out(k)) begin bad++; $display("FAIL scan f=%0d k=%0d got=%h want=%h", f, k, got, exp_out(k)); end
        total++;
        if (frame_tick !== 1'(k == 0)) begin bad++; $display("FAIL scan_tick k=%0d got=%b", k, frame_tick); end
        if (k % 8 == 2) begin
          total++;
          if (an_out !== an_tab[k/8] || seg_out !== seg_tab[k/8]) begin
            bad++; $display("FAIL scan_digit k=%0d an=%b seg=%h want an=%b seg=%h",
                            k, an_out, seg_out, an_tab[k/8], seg_tab[k/8]);
          end
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [11:0] got;
    digit_mask = 4'b0001;
    capture();
    for (int k = 0; k < 32; k++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== exp_out(k)) begin bad++; $display("FAIL mask k=%0d got=%h want=%h", k, got, exp_out(k)); end
      if (k < 8) begin
        total++;
        if (an_out !== 4'b1111) begin bad++; $display("FAIL mask_an0 k=%0d got=%b want=1111", k, an_out); end
      end
      total++;
      if (frame_tick !== 1'(k == 0)) begin bad++; $display("FAIL mask_tick k=%0d got=%b", k, frame_tick); end
    end
    digit_mask = 4'b0000;
  endtask

  task automatic test_dp();
    logic [11:0] got;
    dp_in = 4'b0100;
    capture();
    for (int k = 0; k < 32; k++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== exp_out(k)) begin bad++; $display("FAIL dp k=%0d got=%h want=%h", k, got, exp_out(k)); end
      total++;
      if (dp_out !== 1'(!(k >= 18 && k < 24))) begin bad++; $display("FAIL dp_only2 k=%0d got=%b", k, dp_out); end
    end
    dp_in = 4'b0000;
  endtask

  task automatic test_midframe();
    logic [11:0] got;
    for (int f = 0; f < 2; f++) begin
      capture();
      for (int k = 0; k < 32; k++) begin
        step();
        got = {an_out, seg_out, dp_out};
        total++;
        if (got !== exp_out(k)) begin bad++; $display("FAIL midframe f=%0d k=%0d got=%h want=%h", f, k, got, exp_out(k)); end
        if (k == 18) begin
          total++;
          if (seg_out !== ((f == 0) ? 7'h30 : 7'h00)) begin
            bad++; $display("FAIL midframe_d2 f=%0d got=%h want=%h", f, seg_out, (f == 0) ? 7'h30 : 7'h00);
          end
        end
        if (f == 0 && k == 10) seg2 = 7'h7F;
      end
    end
    seg2 = 7'h4F;
  endtask

  task automatic test_enable();
    logic [11:0] got;
    capture();
    for (int k = 0; k < 20; k++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== exp_out(k)) begin bad++; $display("FAIL en_pre k=%0d got=%h want=%h", k, got, exp_out(k)); end
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== 12'hFFF || frame_tick !== 1'b0) begin
        bad++; $display("FAIL en_off i=%0d got=%h tick=%b want=fff tick=0", i, got, frame_tick);
      end
    end
    enable = 1'b1;
    capture();
    for (int k = 0; k < 32; k++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== exp_out(k)) begin bad++; $display("FAIL en_restart k=%0d got=%h want=%h", k, got, exp_out(k)); end
      total++;
      if (frame_tick !== 1'(k == 0)) begin bad++; $display("FAIL en_tick k=%0d got=%b", k, frame_tick); end
      if (k == 2) begin
        total++;
        if (an_out !== 4'b1110) begin bad++; $display("FAIL en_digit0 got=%b want=1110", an_out); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] got;
    capture();
    for (int k = 0; k < 13; k++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== exp_out(k)) begin bad++; $display("FAIL ar_pre k=%0d got=%h want=%h", k, got, exp_out(k)); end
    end
    #2 reset = 1'b1;
    #1;
    got = {an_out, seg_out, dp_out};
    total++;
    if (got !== 12'hFFF) begin bad++; $display("FAIL ar_async got=%h want=fff", got); end
    step();
    reset = 1'b0;
    total++;
    if (dut.cyc_cnt_r !== 3'd0 || dut.digit_idx_r !== 2'd0 || 2'(dut.state_r) !== 2'd0 ||
        dut.dp_sh_r !== 4'd0 || dut.mask_sh_r !== 4'd0 || frame_tick !== 1'b0) begin
      bad++; $display("FAIL ar_state cyc=%0d dig=%0d st=%0d tick=%b want all 0",
                      dut.cyc_cnt_r, dut.digit_idx_r, dut.state_r, frame_tick);
    end
    capture();
    for (int k = 0; k < 32; k++) begin
      step();
      got = {an_out, seg_out, dp_out};
      total++;
      if (got !== exp_out(k)) begin bad++; $display("FAIL ar_post k=%0d got=%h want=%h", k, got, exp_out(k)); end
      total++;
      if (frame_tick !== 1'(k == 0)) begin bad++; $display("FAIL ar_tick k=%0d got=%b", k, frame_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mask();
    test_dp();
    test_midframe();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DIGIT_CYCLES, default 50000, SHALL set the clk cycles per digit slot; legal range is >= BLANK_CYCLES+2.
REQ-002 Parameter BLANK_CYCLES, default 8, SHALL set the all-off cycles at the start of each slot; legal range is >= 1.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, SHALL select the output polarity of seg_out and dp_out (1 = low lights the segment).
REQ-004 Parameter AN_ACTIVE_LOW, default 1, SHALL select the polarity of an_out (1 = low enables the digit).
REQ-005 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 enable  input  1  SHALL run the scan when high and force IDLE when low.
REQ-008 seg0, seg1, seg2, seg3  input  7 each  SHALL be active-high segment patterns {g..a}; seg0 is the leftmost (minutes) digit, seg3 is the tenths digit.
REQ-009 dp_in  input  4  SHALL be active-high decimal points; bit i belongs to digit i.
REQ-010 digit_mask  input  4  SHALL carry one bit per digit; bit i = 1 blanks digit i (leading-zero suppression).
REQ-011 seg_out  output  7  SHALL be the shared segment bus.
REQ-012 dp_out  output  1  SHALL be the shared decimal point.
REQ-013 an_out  output  4  SHALL be the digit enables; bit i drives digit i.
REQ-014 frame_tick  output  1  SHALL pulse for one cycle at the start of each frame.

Function
REQ-015 All outputs SHALL be driven from registers, with no combinational path from any input to any output.
REQ-016 The block SHALL contain cyc_cnt (0..DIGIT_CYCLES-1), digit_idx (0..3), and states IDLE, BLANK and DRIVE.
REQ-017 IDLE SHALL hold all anodes, segments and dp in the off state, and SHALL hold cyc_cnt = 0 and digit_idx = 0.
REQ-018 IDLE -> BLANK SHALL occur on the first edge with enable = 1; that edge is frame start.
REQ-019 At every frame start, the block SHALL capture seg0..seg3, dp_in and digit_mask into shadow registers; during the frame, outputs SHALL use only the shadow values.
REQ-020 frame_tick SHALL be high in exactly the cycle following each frame-start edge.
REQ-021 BLANK SHALL last BLANK_CYCLES cycles with all outputs off; the state SHALL then go to DRIVE.
REQ-022 DRIVE SHALL last DIGIT_CYCLES-BLANK_CYCLES cycles; during DRIVE, an_out SHALL enable digit digit_idx only, seg_out SHALL carry shadow seg[digit_idx] and dp_out SHALL carry shadow dp[digit_idx], each polarity-adjusted.
REQ-023 If shadow mask[digit_idx] = 1, that digit's DRIVE slot SHALL keep all anodes, segments and dp off; slot timing SHALL be unchanged.
REQ-024 At the end of DRIVE, digit_idx SHALL increment and the state SHALL return to BLANK; the 3 -> 0 wrap SHALL be a frame start (REQ-019, REQ-020).
REQ-025 The frame period SHALL be exactly 4*DIGIT_CYCLES cycles, with no extra cycles at the wrap.
REQ-026 Exactly zero or one anode SHALL be active in any cycle, and an anode change SHALL always be separated by at least BLANK_CYCLES all-off cycles.
REQ-027 enable sampled low in any state SHALL enter IDLE at that edge, and outputs SHALL be off in the next cycle.
REQ-028 If enable falls and rises again, scanning SHALL restart at digit 0 with a new capture.
REQ-029 Input changes mid-frame SHALL have no visible effect until the next frame start.

Reset
REQ-030 While reset is high, the block SHALL force IDLE, cyc_cnt = 0, digit_idx = 0, all shadows = 0 and frame_tick = 0.
REQ-031 While reset is high, an_out SHALL be all-off (4'b1111 at default), seg_out all-off (7'b1111111 at default) and dp_out off (1 at default).
REQ-032 When reset deasserts with enable high, the first frame start SHALL occur on the first subsequent rising clk edge.
REQ-033 A reset asserted mid-DRIVE SHALL blank all outputs asynchronously, with no clock required.

Verification (DIGIT_CYCLES = 8, BLANK_CYCLES = 2, default polarities)
REQ-034 Bench: enable = 1 after reset, seg0..3 = 7'h06/7'h5B/7'h4F/7'h66, mask = 0 -> frame_tick every 32 cycles; each 8-cycle slot = 2 cycles an_out = 4'b1111, then 6 cycles with an_out = 4'b1110/1101/1011/0111 in turn and seg_out = ~pattern.
REQ-035 Bench: digit_mask = 4'b0001 -> during the digit-0 slot an_out stays 4'b1111; digits 1-3 are unchanged; period stays 32.
REQ-036 Bench: change seg2 from 7'h4F to 7'h7F in the digit-1 slot -> the digit-2 slot of the same frame still shows ~7'h4F, and the next frame shows ~7'h7F.
REQ-037 Bench: deassert enable during the digit-2 DRIVE slot -> the next cycle shows all off; on re-enable, frame_tick fires, followed by 2 blank cycles, then digit 0.
REQ-038 Bench: assert reset asynchronously mid-DRIVE -> outputs go all-off before the next clk edge; all state is 0 after release.
REQ-039 Bench: dp_in = 4'b0100 -> dp_out = 0 only during digit-2 DRIVE, and 1 at all other times.
